// File: rtl/bht_predictor.sv
// Branch history table of saturating counters, indexed by PC bits XOR global history (gshare),
// with saturating accuracy counters. Lookup has one cycle of latency; updates train the table.
module bht_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 4,
    parameter int PC_BITS    = 32,
    parameter int PERF_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [PC_BITS-1:0]    req_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    output logic [PERF_BITS-1:0]  perf_updates,
    output logic [PERF_BITS-1:0]  perf_mispred
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    // A one-bit history register is kept even for bimodal builds; it simply stays zero.
    localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0]   table_q [ENTRIES];
    logic [CTR_BITS-1:0]   table_d [ENTRIES];
    logic [GHR_W-1:0]      ghr_q, ghr_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic [PERF_BITS-1:0]  perf_updates_q, perf_updates_d;
    logic [PERF_BITS-1:0]  perf_mispred_q, perf_mispred_d;

    logic [INDEX_BITS-1:0] lookup_index;
    logic [CTR_BITS-1:0]   upd_ctr;
    logic                  unused_pc_bits;

    // Only the word-aligned index slice of the PC matters; higher bits alias by design.
    assign unused_pc_bits = ^{req_pc[PC_BITS-1:INDEX_BITS+2], req_pc[1:0]};
    assign lookup_index   = req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        table_d = table_q;
        upd_ctr = table_q[upd_index];
        if (upd_valid) begin
            if (upd_taken && upd_ctr != CTR_MAX) begin
                table_d[upd_index] = upd_ctr + CTR_BITS'(1);
            end else if (!upd_taken && upd_ctr != '0) begin
                table_d[upd_index] = upd_ctr - CTR_BITS'(1);
            end
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (GHR_BITS > 0 && upd_valid) begin
            ghr_d = GHR_W'({ghr_q, upd_taken});
        end
    end

    // Lookup reads the pre-update table and history; there is no bypass from the update port.
    always_comb begin
        pred_valid_d = req_valid;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (req_valid) begin
            pred_taken_d = table_q[lookup_index][CTR_BITS-1];
            pred_index_d = lookup_index;
        end
    end

    always_comb begin
        perf_updates_d = perf_updates_q;
        perf_mispred_d = perf_mispred_q;
        if (upd_valid) begin
            if (perf_updates_q != '1) begin
                perf_updates_d = perf_updates_q + PERF_BITS'(1);
            end
            if (upd_pred != upd_taken && perf_mispred_q != '1) begin
                perf_mispred_d = perf_mispred_q + PERF_BITS'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is reset because predictions must start weakly not-taken.
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_INIT;
            end
            ghr_q          <= '0;
            pred_valid_q   <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_index_q   <= '0;
            perf_updates_q <= '0;
            perf_mispred_q <= '0;
        end else begin
            table_q        <= table_d;
            ghr_q          <= ghr_d;
            pred_valid_q   <= pred_valid_d;
            pred_taken_q   <= pred_taken_d;
            pred_index_q   <= pred_index_d;
            perf_updates_q <= perf_updates_d;
            perf_mispred_q <= perf_mispred_d;
        end
    end

    assign pred_valid   = pred_valid_q;
    assign pred_taken   = pred_taken_q;
    assign pred_index   = pred_index_q;
    assign perf_updates = perf_updates_q;
    assign perf_mispred = perf_mispred_q;

endmodule

// File: doc/bht_predictor.md
# bht_predictor

Parametrised branch history table: an array of saturating counters indexed by PC bits, optionally XOR-hashed with a global history register (gshare), plus built-in accuracy counters. It is the next-generation replacement for the single 2-bit counter predictor. It sits beside fetch: fetch issues a lookup per branch, and execute returns the resolved outcome to train the table.

## Interface
Parameters:
- INDEX_BITS, 6: table has 2^INDEX_BITS entries.
- CTR_BITS, 2: counter width, 1..4.
- GHR_BITS, 4: global history length, 0..INDEX_BITS. 0 = pure bimodal.
- PC_BITS, 32: PC width, must be ≥ INDEX_BITS+2.
- PERF_BITS, 16: width of the accuracy counters.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  lookup request.
- req_pc  in  PC_BITS  branch PC.
- pred_valid  out  1  prediction valid, one cycle after req_valid.
- pred_taken  out  1  predicted direction.
- pred_index  out  INDEX_BITS  table index used; fetch carries it to resolution.
- upd_valid  in  1  resolved-branch update.
- upd_index  in  INDEX_BITS  index returned from pred_index.
- upd_taken  in  1  actual outcome.
- upd_pred  in  1  prediction that was issued for this branch.
- perf_updates  out  PERF_BITS  number of updates, saturating.
- perf_mispred  out  PERF_BITS  number of updates with upd_pred != upd_taken, saturating.

## Operation
- Lookup index: req_pc[INDEX_BITS+1:2] XOR {zeros, ghr}, with ghr zero-extended on the left. If GHR_BITS=0, the index is the PC slice alone.
- Prediction is the MSB of the indexed counter: 1 = taken.
- Counter init and reset value: 2^(CTR_BITS-1)-1, i.e. weakly not-taken. This is 01 for CTR_BITS=2 and 0 for CTR_BITS=1.
- Update with upd_taken=1: counter +1, saturating at 2^CTR_BITS-1.
- Update with upd_taken=0: counter −1, saturating at 0.
- No other counter changes occur.
- GHR (GHR_BITS>0): on upd_valid, ghr <= {ghr[GHR_BITS-2:0], upd_taken}. This is non-speculative; only resolved outcomes enter the history. For GHR_BITS=1, ghr <= upd_taken.
- Perf counters: on upd_valid, perf_updates += 1. If upd_pred != upd_taken, perf_mispred also += 1. Each counter holds at all-ones.
- Lookup and update are independent and may both occur in any cycle, including to the same index.

## Timing
- Lookup latency is 1 cycle. A req_valid sampled at edge N produces pred_valid/pred_taken/pred_index, stable after edge N and valid for the cycle following it.
- pred_valid mirrors req_valid delayed by one cycle. When pred_valid=0, pred_taken and pred_index hold their previous values.
- Update is written at the edge where upd_valid is sampled. A lookup sampled at that same edge reads the pre-update counter and uses the pre-update ghr. There is no bypass.
- A lookup sampled at the next edge sees the new counter and ghr.
- Reset (rst=1 at an edge) takes priority over everything and sets:
  - every counter to init;
  - ghr to 0;
  - pred_valid, pred_taken, pred_index to 0;
  - perf_updates and perf_mispred to 0.
- A request or update coincident with reset is dropped. A prediction in flight when rst asserts does not appear.
- The first lookup after reset releases sees init counters, so it predicts not-taken for CTR_BITS ≥ 1.
- Saturation boundaries: with CTR_BITS=2, 11 + taken stays 11, and 00 + not-taken stays 00. perf_* at all-ones stay at all-ones.
- Index arithmetic is a plain XOR in INDEX_BITS width; PC bits above INDEX_BITS+1 are ignored, so aliasing is expected.

## Test plan
- Reset, then req_pc=0x40 with defaults (GHR 0): pred_valid=1 the next cycle, pred_index=0x10, pred_taken=0.
- Three upd_valid taken updates to index 0x10 (GHR_BITS=0 build): the counter goes 01→10→11→11. A lookup of 0x40 after the first update predicts taken. Two not-taken updates then give 01 and predict not-taken.
- Same-cycle lookup and update to index 0x10 from counter 01 with upd_taken=1: that lookup returns not-taken. A lookup the next cycle returns taken.
- Gshare default (GHR_BITS=4): updates taken, taken, not-taken, taken give ghr=1101. A lookup of req_pc=0x40 then yields pred_index=0x10^0x0D=0x1D.
- Perf counters with PERF_BITS=2: five updates, three with upd_pred != upd_taken, give perf_updates=3 (saturated) and perf_mispred=3. A rst pulse returns both to 0.
- Assert rst for one cycle mid-stream with a request and an update in the same cycle: no pred_valid follows, all counters read back at init, ghr=0.
